util_fifo_wr_arb: RTL and testbench
===================================

UTIL_FIFO_WR_ARB -- requirements
Module: util_fifo_wr_arb

Interface
REQ-001 SHALL provide parameter NUM_REQ, default 4, number of write requesters (2..8).
REQ-002 SHALL provide parameter DATA_WIDTH, default 8, data bits per beat.
REQ-003 SHALL provide parameter MAX_BEATS, default 256, maximum beats per grant before forced release (>=1).
REQ-004 SHALL have port clk  input  1  single clock for all logic.
REQ-005 SHALL have port rstn  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port s_data  input  NUM_REQ*DATA_WIDTH  requester data; lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 SHALL have port s_valid  input  NUM_REQ  per-requester beat valid.
REQ-008 SHALL have port s_last  input  NUM_REQ  per-requester end-of-packet marker.
REQ-009 SHALL have port s_ready  output  NUM_REQ  per-requester beat accept.
REQ-010 SHALL have port wr_en  output  1  FIFO write enable, to util_fifo wr_en.
REQ-011 SHALL have port wr_data  output  DATA_WIDTH  FIFO write data, to util_fifo wr_data.
REQ-012 SHALL have port wr_full  input  1  FIFO full, from util_fifo wr_full.
REQ-013 SHALL have port grant  output  clog2(NUM_REQ)  index of current owner.
REQ-014 SHALL have port busy  output  1  high while in GRANT.
REQ-015 SHALL have port overrun  output  1  sticky flag, forced release occurred.

Function
REQ-016 SHALL implement two states: IDLE and GRANT.
REQ-017 In IDLE with any s_valid high, SHALL select the first requester with s_valid high, searching round-robin from last_grant+1 (mod NUM_REQ); it SHALL load grant and enter GRANT on the next edge.
REQ-018 In IDLE with no s_valid high, SHALL remain in IDLE; grant holds its value.
REQ-019 SHALL make s_ready[i] = (state==GRANT) & (grant==i) & ~wr_full, combinationally; all other lanes 0.
REQ-020 SHALL drive wr_en = s_valid[grant] & s_ready[grant] and wr_data = lane grant of s_data, combinationally (zero latency), so no write is issued while wr_full is high.
REQ-021 SHALL count accepted beats in GRANT with a counter wide enough for MAX_BEATS, cleared on entry to GRANT.
REQ-022 On an accepted beat with s_last[grant] high, SHALL set last_grant <= grant and return to IDLE.
REQ-023 On the accepted beat that brings the count to MAX_BEATS without s_last, SHALL set overrun, set last_grant <= grant, and return to IDLE.
REQ-024 If both REQ-022 and REQ-023 apply on the same beat, SHALL treat it as normal end-of-packet; overrun SHALL NOT be set.
REQ-025 SHALL hold the grant through s_valid gaps and wr_full stalls; packets from different requesters SHALL never interleave.
REQ-026 SHALL insert exactly one IDLE cycle between consecutive grants (arbitration latency: 1 cycle from IDLE to first possible acceptance).
REQ-027 busy SHALL equal (state==GRANT).
REQ-028 overrun SHALL clear only on reset.

Reset
REQ-029 On rstn low, SHALL asynchronously force state=IDLE, grant=0, last_grant=NUM_REQ-1, beat counter=0, overrun=0; consequently s_ready=0, wr_en=0, busy=0.
REQ-030 Reset asserted mid-packet SHALL abandon the packet; after release, arbitration restarts with requester 0 highest priority.
REQ-031 SHALL resume operation on the first rising clk edge after rstn deasserts, with no additional synchronising delay.

Verification
REQ-032 Single requester: lane 2 sends 4 beats 0x10..0x13, last on 4th -> grant=2 one cycle after valid, wr_en high 4 consecutive cycles with wr_data 0x10..0x13, then IDLE.
REQ-033 Round-robin: all 4 lanes valid continuously with 1-beat packets after reset -> grant order 0,1,2,3,0, one IDLE cycle between each.
REQ-034 Backpressure: wr_full high for 5 cycles mid-packet on lane 1 -> s_ready[1]=0 and wr_en=0 those cycles, no beat lost or duplicated, grant stays 1.
REQ-035 Overrun: MAX_BEATS=8, lane 0 sends 12 beats without last -> release after 8th beat, overrun=1, next grant goes to another valid lane or returns to lane 0 if none else valid.
REQ-036 Last on MAX_BEATS-th beat: MAX_BEATS=8, 8-beat packet with last on 8th -> overrun remains 0.
REQ-037 Reset mid-packet: rstn low during 3rd beat of lane 3 -> s_ready, wr_en, busy 0 immediately; after release with lanes 0 and 3 valid -> grant=0 first.

Source files
------------

// File: rtl/util_fifo_wr_arb.sv
// Round-robin write arbiter: grants one requester at a time a packet-long
// path into a single util_fifo write port, with a per-grant beat limit.
module util_fifo_wr_arb #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BEATS  = 256
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] s_data,
  input  logic [NUM_REQ-1:0]            s_valid,
  input  logic [NUM_REQ-1:0]            s_last,
  output logic [NUM_REQ-1:0]            s_ready,
  output logic                          wr_en,
  output logic [DATA_WIDTH-1:0]         wr_data,
  input  logic                          wr_full,
  output logic [$clog2(NUM_REQ)-1:0]    grant,
  output logic                          busy,
  output logic                          overrun
);

  localparam int          GW       = $clog2(NUM_REQ);
  localparam int          CW       = $clog2(MAX_BEATS + 1);
  localparam int unsigned NREQ     = NUM_REQ;
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BEATS - 1);
  localparam logic [GW-1:0] GRANT_RST_LAST = GW'(NUM_REQ - 1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t          state, state_nxt;
  logic [GW-1:0]   grant_q, grant_nxt;
  logic [GW-1:0]   last_grant, last_grant_nxt;
  logic [CW-1:0]   beat_cnt, beat_cnt_nxt;
  logic            overrun_q, overrun_nxt;

  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  accept;
  logic                  pick_found;
  logic [GW-1:0]         pick_idx;
  logic [GW-1:0]         scan_idx;

  // Owner lane mux, written as a compare loop so non-power-of-two NUM_REQ
  // never indexes past the last lane.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_q == GW'(i)) begin
        sel_valid = s_valid[i];
        sel_last  = s_last[i];
        sel_data  = s_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    s_ready = '0;
    if (state == GRANT && !wr_full) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        s_ready[i] = (grant_q == GW'(i));
      end
    end
  end

  assign accept  = (state == GRANT) && !wr_full && sel_valid;
  assign wr_en   = accept;
  assign wr_data = sel_data;

  // Round-robin scan starting just after the previous owner.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      scan_idx = GW'((32'(last_grant) + k + 1) % NREQ);
      if (!pick_found && s_valid[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant_q;
    last_grant_nxt = last_grant;
    beat_cnt_nxt   = beat_cnt;
    overrun_nxt    = overrun_q;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_nxt    = GRANT;
          grant_nxt    = pick_idx;
          beat_cnt_nxt = '0;
        end
      end
      GRANT: begin
        if (accept) begin
          beat_cnt_nxt = beat_cnt + 1'b1;
          // End-of-packet takes precedence over the beat-limit release.
          if (sel_last) begin
            state_nxt      = IDLE;
            last_grant_nxt = grant_q;
          end else if (beat_cnt == CNT_LAST) begin
            state_nxt      = IDLE;
            last_grant_nxt = grant_q;
            overrun_nxt    = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      grant_q    <= '0;
      last_grant <= GRANT_RST_LAST;
      beat_cnt   <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state      <= state_nxt;
      grant_q    <= grant_nxt;
      last_grant <= last_grant_nxt;
      beat_cnt   <= beat_cnt_nxt;
      overrun_q  <= overrun_nxt;
    end
  end

  assign grant   = grant_q;
  assign busy    = (state == GRANT);
  assign overrun = overrun_q;

endmodule

// File: tb/tb_util_fifo_wr_arb.sv
// Directed bench for util_fifo_wr_arb (4 lanes, 8-bit data, 8-beat limit).
module tb_util_fifo_wr_arb;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 8;

  logic             clk = 1'b0;
  logic             rstn;
  logic [NR*DW-1:0] s_data;
  logic [NR-1:0]    s_valid;
  logic [NR-1:0]    s_last;
  logic [NR-1:0]    s_ready;
  logic             wr_en;
  logic [DW-1:0]    wr_data;
  logic             wr_full;
  logic [1:0]       grant;
  logic             busy;
  logic             overrun;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  util_fifo_wr_arb #(
    .NUM_REQ   (NR),
    .DATA_WIDTH(DW),
    .MAX_BEATS (MB)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .s_data (s_data),
    .s_valid(s_valid),
    .s_last (s_last),
    .s_ready(s_ready),
    .wr_en  (wr_en),
    .wr_data(wr_data),
    .wr_full(wr_full),
    .grant  (grant),
    .busy   (busy),
    .overrun(overrun)
  );

  // Returns at a falling edge with rstn just released and inputs idle.
  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0; s_valid = '0; s_last = '0; s_data = '0; wr_full = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    s_valid = '0; s_last = '0; s_data = '0; wr_full = 1'b0; rstn = 1'b1;
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_cmp++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL reset_wr_en got %b exp 0", wr_en); end
    n_cmp++; if (s_ready !== 4'b0000) begin n_err++; $display("FAIL reset_s_ready got %b exp 0000", s_ready); end
    n_cmp++; if (grant !== 2'd0) begin n_err++; $display("FAIL reset_grant got %0d exp 0", grant); end
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun got %b exp 0", overrun); end
    s_valid = 4'b1111;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_hold_busy got %b exp 0", busy); end
    s_valid = '0;
    rstn = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    for (int c = 0; c <= 5; c++) begin
      if (c > 0) @(negedge clk);
      s_valid = (c <= 4) ? 4'b0100 : 4'b0000;
      s_data[2*DW +: DW] = (c >= 1) ? 8'(8'h10 + c - 1) : 8'h10;
      s_last = (c == 4) ? 4'b0100 : 4'b0000;
      #1;
      if (c == 0 || c == 5) begin
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_idle_busy c=%0d got %b exp 0", c, busy); end
        n_cmp++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL single_idle_wr_en c=%0d got %b exp 0", c, wr_en); end
      end else begin
        n_cmp++; if (grant !== 2'd2) begin n_err++; $display("FAIL single_grant c=%0d got %0d exp 2", c, grant); end
        n_cmp++; if (wr_en !== 1'b1) begin n_err++; $display("FAIL single_wr_en c=%0d got %b exp 1", c, wr_en); end
        n_cmp++; if (wr_data !== 8'(8'h10 + c - 1)) begin n_err++; $display("FAIL single_wr_data c=%0d got %h exp %h", c, wr_data, 8'(8'h10 + c - 1)); end
        n_cmp++; if (s_ready !== 4'b0100) begin n_err++; $display("FAIL single_s_ready c=%0d got %b exp 0100", c, s_ready); end
      end
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g;
    do_reset();
    s_valid = 4'b1111; s_last = 4'b1111;
    for (int i = 0; i < NR; i++) s_data[i*DW +: DW] = 8'(8'hA0 + i);
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      exp_g = 2'((c / 2) % 4);
      n_cmp++; if (busy !== 1'(c % 2)) begin n_err++; $display("FAIL rr_busy c=%0d got %b exp %0d", c, busy, c % 2); end
      if (c % 2 == 1) begin
        n_cmp++; if (grant !== exp_g) begin n_err++; $display("FAIL rr_grant c=%0d got %0d exp %0d", c, grant, exp_g); end
        n_cmp++; if (wr_data !== 8'(8'hA0 + exp_g)) begin n_err++; $display("FAIL rr_wr_data c=%0d got %h exp %h", c, wr_data, 8'(8'hA0 + exp_g)); end
      end else begin
        n_cmp++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL rr_gap_wr_en c=%0d got %b exp 0", c, wr_en); end
      end
    end
    @(negedge clk);
    s_valid = '0; s_last = '0;
  endtask

  task automatic test_backpressure();
    int  idx;
    int  n_wr;
    logic full, exp_en;
    do_reset();
    idx = 0; n_wr = 0;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      full = (c >= 3 && c < 8);
      wr_full = full;
      s_valid = 4'b0010;
      s_data[1*DW +: DW] = 8'(8'h20 + idx);
      s_last = (idx == 5) ? 4'b0010 : 4'b0000;
      #1;
      exp_en = (c >= 1) && !full;
      if (wr_en === 1'b1) n_wr++;
      n_cmp++; if (wr_en !== exp_en) begin n_err++; $display("FAIL bp_wr_en c=%0d got %b exp %b", c, wr_en, exp_en); end
      n_cmp++; if (s_ready !== (exp_en ? 4'b0010 : 4'b0000)) begin n_err++; $display("FAIL bp_s_ready c=%0d got %b exp %b", c, s_ready, exp_en ? 4'b0010 : 4'b0000); end
      if (c >= 1) begin
        n_cmp++; if (grant !== 2'd1) begin n_err++; $display("FAIL bp_grant c=%0d got %0d exp 1", c, grant); end
      end
      if (exp_en) begin
        n_cmp++; if (wr_data !== 8'(8'h20 + idx)) begin n_err++; $display("FAIL bp_wr_data c=%0d got %h exp %h", c, wr_data, 8'(8'h20 + idx)); end
        idx++;
      end
    end
    @(negedge clk);
    s_valid = '0; s_last = '0; wr_full = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL bp_end_busy got %b exp 0", busy); end
    n_cmp++; if (n_wr !== 6) begin n_err++; $display("FAIL bp_write_count got %0d exp 6", n_wr); end
  endtask

  task automatic test_overrun();
    do_reset();
    for (int c = 0; c <= 8; c++) begin
      if (c > 0) @(negedge clk);
      s_valid = 4'b0001; s_last = '0;
      s_data[0 +: DW] = (c >= 1) ? 8'(8'h30 + c - 1) : 8'h30;
      #1;
      if (c == 0) begin
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ovr_idle_busy got %b exp 0", busy); end
      end else begin
        n_cmp++; if (wr_data !== 8'(8'h30 + c - 1) || wr_en !== 1'b1) begin n_err++; $display("FAIL ovr_beat c=%0d got en=%b data=%h exp en=1 data=%h", c, wr_en, wr_data, 8'(8'h30 + c - 1)); end
      end
    end
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_early got %b exp 0", overrun); end
    @(negedge clk);
    s_data[0 +: DW] = 8'h38;
    s_valid = 4'b0101; s_last = 4'b0100; s_data[2*DW +: DW] = 8'h55;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ovr_release_busy got %b exp 0", busy); end
    n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_flag got %b exp 1", overrun); end
    n_cmp++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL ovr_release_wr_en got %b exp 0", wr_en); end
    @(negedge clk);
    #1;
    n_cmp++; if (grant !== 2'd2 || wr_data !== 8'h55) begin n_err++; $display("FAIL ovr_next_grant got g=%0d d=%h exp g=2 d=55", grant, wr_data); end
    @(negedge clk);
    s_valid = 4'b0001; s_last = '0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ovr_gap_busy got %b exp 0", busy); end
    @(negedge clk);
    #1;
    n_cmp++; if (grant !== 2'd0 || wr_data !== 8'h38 || wr_en !== 1'b1) begin n_err++; $display("FAIL ovr_back_to_0 got g=%0d d=%h en=%b exp g=0 d=38 en=1", grant, wr_data, wr_en); end
    n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_sticky got %b exp 1", overrun); end
    @(negedge clk);
    s_valid = '0;
  endtask

  task automatic test_last_on_max();
    do_reset();
    for (int c = 0; c <= 9; c++) begin
      if (c > 0) @(negedge clk);
      s_valid = (c <= 8) ? 4'b0010 : 4'b0000;
      s_last = (c == 8) ? 4'b0010 : 4'b0000;
      s_data[1*DW +: DW] = 8'(8'h70 + c);
      #1;
      if (c == 8) begin
        n_cmp++; if (wr_en !== 1'b1 || wr_data !== 8'h78) begin n_err++; $display("FAIL lom_beat8 got en=%b d=%h exp en=1 d=78", wr_en, wr_data); end
      end
    end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL lom_busy got %b exp 0", busy); end
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL lom_overrun got %b exp 0", overrun); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c <= 3; c++) begin
      if (c > 0) @(negedge clk);
      s_valid = 4'b1000; s_last = '0;
      s_data[3*DW +: DW] = 8'(8'h40 + c);
    end
    #1;
    n_cmp++; if (wr_en !== 1'b1 || grant !== 2'd3) begin n_err++; $display("FAIL rmid_pre got en=%b g=%0d exp en=1 g=3", wr_en, grant); end
    rstn = 1'b0;
    #1;
    n_cmp++; if (s_ready !== 4'b0000) begin n_err++; $display("FAIL rmid_s_ready got %b exp 0000", s_ready); end
    n_cmp++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL rmid_wr_en got %b exp 0", wr_en); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy got %b exp 0", busy); end
    s_valid = 4'b1001; s_last = 4'b1001;
    s_data[0 +: DW] = 8'h60;
    @(negedge clk);
    rstn = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_post_idle got %b exp 0", busy); end
    @(negedge clk);
    #1;
    n_cmp++; if (grant !== 2'd0 || busy !== 1'b1 || wr_data !== 8'h60) begin n_err++; $display("FAIL rmid_first_grant got g=%0d b=%b d=%h exp g=0 b=1 d=60", grant, busy, wr_data); end
    @(negedge clk);
    s_valid = '0; s_last = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_overrun();
    test_last_on_max();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout compared=%0d mismatched=%0d", n_cmp, n_err);
    $fatal(1);
  end

endmodule
